// File: rtl/uart_thr_pkg.sv
// Shared encodings for the UART threshold-register parser.
package uart_thr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int         NUM_REGS = 8;

endpackage

// File: rtl/uart_threshold_parser.sv
// Parses A5/addr/data/chk frames from a UART byte stream into eight 8-bit threshold registers.
// Latency 1 cycle from the chk strobe; no backpressure, bytes are consumed as strobed.
module uart_threshold_parser
  import uart_thr_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 500000,
  parameter logic [63:0] TH_INIT        = 64'h0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [63:0] th_regs,
  output logic        cfg_update,
  output logic        frame_err
);

  localparam logic [23:0] CNT_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_addr;
  logic [7:0]  r_data;
  logic [23:0] r_cnt;
  logic [23:0] w_cnt_nxt;
  logic [63:0] r_th;
  logic        r_cfg;
  logic        r_err;
  logic        w_wr;
  logic        w_err;
  logic        w_timeout;
  logic        w_lat_addr;
  logic        w_lat_data;
  logic [7:0]  w_sum;

  assign w_sum = r_addr + r_data;

  // A strobe in the same cycle as the counter expiry takes priority.
  assign w_timeout = (r_state != ST_IDLE) && !rx_done && (r_cnt == CNT_LAST);

  assign w_cnt_nxt = (rx_done || (r_state == ST_IDLE) || w_timeout) ? 24'd0 : r_cnt + 24'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_err       = 1'b0;
    w_lat_addr  = 1'b0;
    w_lat_data  = 1'b0;
    case (r_state)
      ST_IDLE: if (rx_done && rx_data == HDR_BYTE) w_state_nxt = ST_ADDR;
      ST_ADDR: if (rx_done) begin
        w_state_nxt = ST_DATA;
        w_lat_addr  = 1'b1;
      end
      ST_DATA: if (rx_done) begin
        w_state_nxt = ST_CHK;
        w_lat_data  = 1'b1;
      end
      ST_CHK: if (rx_done) begin
        w_state_nxt = ST_IDLE;
        if (rx_data == w_sum && r_addr < 8'(NUM_REGS)) w_wr = 1'b1;
        else                                           w_err = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_err       = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= 8'd0;
      r_data  <= 8'd0;
      r_cnt   <= 24'd0;
      r_th    <= TH_INIT;
      r_cfg   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cfg   <= w_wr;
      r_err   <= w_err;
      if (w_lat_addr) r_addr <= rx_data;
      if (w_lat_data) r_data <= rx_data;
      for (int n = 0; n < NUM_REGS; n++) begin
        if (w_wr && r_addr == 8'(n)) r_th[8*n +: 8] <= r_data;
      end
    end
  end

  assign th_regs    = r_th;
  assign cfg_update = r_cfg;
  assign frame_err  = r_err;

endmodule
